// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage driving a request/acknowledge data-memory port.
// Holds the pipeline (m_busy) while an access is outstanding, reports address,
// bus-error and timeout faults as ADR status, and returns loaded data for reads.
module mem_stage #(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] MEM_MAX = 64'd8191,
  parameter logic [7:0]        TIMEOUT = 8'd16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        M_stat,
  input  logic [3:0]        M_icode,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] M_valA,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              mem_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        m_stat,
  output logic [DATA_W-1:0] m_valM,
  output logic              m_busy
);

  localparam logic [1:0] S_AOK = 2'd0;
  localparam logic [1:0] S_ADR = 2'd2;

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state;
  state_t            state_nxt;

  logic              wr_op;
  logic              rd_op;
  logic              need_mem;
  logic [DATA_W-1:0] tgt_addr;
  logic              addr_ok;

  logic              launch;
  logic              ack_done;
  logic              to_hit;

  logic [7:0]        cnt;
  logic [7:0]        cnt_inc;
  logic              err_p1;
  logic [DATA_W-1:0] rdata_p1;

  function automatic logic is_write_op(input logic [3:0] icode);
    return (icode == I_RMMOVQ) || (icode == I_PUSHQ) || (icode == I_CALL);
  endfunction

  function automatic logic is_read_op(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ) || (icode == I_RET);
  endfunction

  // Stack pops (popq/ret) address through valA; everything else through valE.
  function automatic logic [DATA_W-1:0] access_addr(input logic [3:0]        icode,
                                                    input logic [DATA_W-1:0] vale,
                                                    input logic [DATA_W-1:0] vala);
    return ((icode == I_POPQ) || (icode == I_RET)) ? vala : vale;
  endfunction

  assign wr_op    = is_write_op(M_icode);
  assign rd_op    = is_read_op(M_icode);
  assign need_mem = (wr_op || rd_op) && (M_stat == S_AOK);
  assign tgt_addr = access_addr(M_icode, M_valE, M_valA);
  assign addr_ok  = (tgt_addr <= MEM_MAX);
  assign cnt_inc  = cnt + 8'd1;

  // State register: reset abandons any outstanding access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode, access strobes and stage outputs.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    ack_done  = 1'b0;
    to_hit    = 1'b0;
    m_busy    = 1'b0;
    m_stat    = S_AOK;
    m_valM    = '0;
    case (state)
      IDLE: begin
        if (need_mem && addr_ok) begin
          launch    = 1'b1;
          m_busy    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        m_busy = 1'b1;
        // An ack in the final permitted cycle wins over the timeout.
        if (mem_ack) begin
          ack_done  = 1'b1;
          state_nxt = DONE;
        end else if (cnt_inc == TIMEOUT) begin
          to_hit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        if (rd_op) begin
          m_valM = rdata_p1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (M_stat != S_AOK) begin
      m_stat = M_stat;
    end else if (need_mem && !addr_ok) begin
      m_stat = S_ADR;
    end else if ((state == DONE) && err_p1) begin
      m_stat = S_ADR;
    end
  end

  // Memory port registers: loaded on launch, request dropped on ack or timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (launch) begin
        mem_req   <= 1'b1;
        mem_we    <= wr_op;
        mem_addr  <= tgt_addr;
        mem_wdata <= wr_op ? M_valA : '0;
      end else if (ack_done || to_hit) begin
        mem_req <= 1'b0;
      end
    end
  end

  // Timeout counter: cleared on launch, counts every cycle spent waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (launch) begin
      cnt <= 8'd0;
    end else if (state == WAIT) begin
      cnt <= cnt_inc;
    end
  end

  // Completion capture: bus error / timeout flag and read data for the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      if (ack_done) begin
        err_p1 <= mem_err;
        if (!mem_we) begin
          rdata_p1 <= mem_rdata;
        end
      end else if (to_hit) begin
        err_p1 <= 1'b1;
      end else if (state == DONE) begin
        err_p1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized accesses against a transaction-level model
// of the memory stage (access classification, latency and fault reporting).
module tb_mem_stage;

  localparam logic [63:0] MEM_MAX = 64'd8191;
  localparam int          TMO     = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  M_stat;
  logic [3:0]  M_icode;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic        mem_err;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [1:0]  m_stat;
  logic [63:0] m_valM;
  logic        m_busy;

  int n_cmp = 0;
  int n_bad = 0;

  mem_stage #(
    .DATA_W (64),
    .MEM_MAX(MEM_MAX),
    .TIMEOUT(8'd16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .M_stat   (M_stat),
    .M_icode  (M_icode),
    .M_valE   (M_valE),
    .M_valA   (M_valA),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .mem_err  (mem_err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .m_stat   (m_stat),
    .m_valM   (m_valM),
    .m_busy   (m_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_write(input logic [3:0] ic);
    return (ic == 4'h4) || (ic == 4'hA) || (ic == 4'h8);
  endfunction

  function automatic bit is_read(input logic [3:0] ic);
    return (ic == 4'h5) || (ic == 4'hB) || (ic == 4'h9);
  endfunction

  function automatic logic [63:0] target(input logic [3:0] ic, input logic [63:0] ve,
                                         input logic [63:0] va);
    return ((ic == 4'hB) || (ic == 4'h9)) ? va : ve;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction through the stage. d = cycle (1-based) of mem_req in which
  // memory acks; d > TMO means memory never answers.
  task automatic access(input logic [1:0] st, input logic [3:0] ic, input logic [63:0] ve,
                        input logic [63:0] va, input int d, input logic er,
                        input logic [63:0] rd);
    bit          mem;
    bit          go;
    bit          timed_out;
    bit          fault;
    int          last;
    int          busy_seen;
    logic [63:0] a;
    logic [1:0]  exp_st;
    M_stat    = st;
    M_icode   = ic;
    M_valE    = ve;
    M_valA    = va;
    mem_ack   = 1'b0;
    mem_err   = 1'b0;
    mem_rdata = 64'd0;
    mem       = is_write(ic) || is_read(ic);
    a         = target(ic, ve, va);
    go        = mem && (st == 2'd0) && (a <= MEM_MAX);
    if (!go) begin
      exp_st    = (st != 2'd0) ? st : (mem ? 2'd2 : 2'd0);
      mem_ack   = 1'($urandom_range(0, 1));
      mem_err   = 1'b1;
      mem_rdata = {$urandom, $urandom};
      @(negedge clk);
      check("noacc_busy", 64'(m_busy), 64'd0);
      check("noacc_req", 64'(mem_req), 64'd0);
      check("noacc_stat", 64'(m_stat), 64'(exp_st));
      check("noacc_valM", m_valM, 64'd0);
      tick();
      mem_ack = 1'b0;
      return;
    end
    timed_out = (d > TMO);
    last      = timed_out ? TMO : d;
    fault     = timed_out ? 1'b1 : er;
    @(negedge clk);
    busy_seen = m_busy ? 1 : 0;
    check("issue_req", 64'(mem_req), 64'd0);
    check("issue_stat", 64'(m_stat), 64'd0);
    tick();
    for (int c = 1; c <= last; c++) begin
      mem_ack   = (c == d);
      mem_err   = (c == d) ? er : 1'($urandom_range(0, 1));
      mem_rdata = (c == d) ? rd : {$urandom, $urandom};
      @(negedge clk);
      if (m_busy) busy_seen++;
      check("wait_req", 64'(mem_req), 64'd1);
      check("wait_we", 64'(mem_we), 64'(is_write(ic)));
      check("wait_addr", mem_addr, a);
      if (is_write(ic)) check("wait_wdata", mem_wdata, va);
      tick();
    end
    // Stray strobes while the result is presented must be ignored.
    mem_ack   = 1'($urandom_range(0, 1));
    mem_err   = 1'b1;
    mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    if (m_busy) busy_seen++;
    check("done_req", 64'(mem_req), 64'd0);
    check("done_stat", 64'(m_stat), fault ? 64'd2 : 64'd0);
    if (!(timed_out && is_read(ic)))
      check("done_valM", m_valM, (is_read(ic) && !timed_out) ? rd : 64'd0);
    check("busy_cycles", 64'(busy_seen), 64'(1 + last));
    tick();
    mem_ack = 1'b0;
  endtask

  // Reset asserted while an access is outstanding; the late ack must vanish.
  task automatic reset_in_wait();
    M_stat    = 2'd0;
    M_icode   = 4'h5;
    M_valE    = 64'h300;
    M_valA    = 64'd0;
    mem_ack   = 1'b0;
    mem_err   = 1'b0;
    mem_rdata = 64'd0;
    tick();
    tick();
    @(negedge clk);
    check("rstw_req_before", 64'(mem_req), 64'd1);
    #2;
    rst     = 1'b1;
    M_icode = 4'h1;
    #1;
    check("rstw_req_async", 64'(mem_req), 64'd0);
    check("rstw_busy_async", 64'(m_busy), 64'd0);
    #1;
    rst = 1'b0;
    tick();
    mem_ack   = 1'b1;
    mem_err   = 1'b1;
    mem_rdata = 64'hCAFEF00D;
    @(negedge clk);
    check("rstw_ack_busy", 64'(m_busy), 64'd0);
    check("rstw_ack_req", 64'(mem_req), 64'd0);
    tick();
    mem_ack = 1'b0;
    mem_err = 1'b0;
    @(negedge clk);
    check("rstw_after_busy", 64'(m_busy), 64'd0);
    check("rstw_after_stat", 64'(m_stat), 64'd0);
    check("rstw_after_valM", m_valM, 64'd0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    M_stat    = 2'd0;
    M_icode   = 4'h1;
    M_valE    = 64'd0;
    M_valA    = 64'd0;
    mem_rdata = 64'd0;
    mem_ack   = 1'b0;
    mem_err   = 1'b0;
    @(negedge clk);
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_addr", mem_addr, 64'd0);
    check("rst_wdata", mem_wdata, 64'd0);
    check("rst_busy", 64'(m_busy), 64'd0);
    check("rst_stat", 64'(m_stat), 64'd0);
    check("rst_valM", m_valM, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Directed scenarios
    access(2'd0, 4'h5, 64'h100, 64'h7, 3, 1'b0, 64'hDEADBEEF);
    access(2'd0, 4'h4, 64'h40, 64'h1234, 1, 1'b0, 64'h99);
    access(2'd0, 4'hB, 64'h10, 64'h2000, 1, 1'b0, 64'h0);
    access(2'd0, 4'h8, 64'h80, 64'h55, 999, 1'b0, 64'h0);
    access(2'd0, 4'h9, 64'h0, 64'h10, 2, 1'b1, 64'h1111);
    access(2'd1, 4'h4, 64'h40, 64'h1234, 1, 1'b0, 64'h0);
    access(2'd0, 4'h5, 64'd8191, 64'h0, 2, 1'b0, 64'hA5A5);
    access(2'd0, 4'h5, 64'd8192, 64'h0, 2, 1'b0, 64'hA5A5);
    access(2'd0, 4'hA, 64'h20, 64'hBEEF, 16, 1'b0, 64'h0);
    access(2'd0, 4'hB, 64'h0, 64'h30, 17, 1'b0, 64'h1);
    access(2'd3, 4'h5, 64'h100, 64'h0, 1, 1'b0, 64'h1);
    access(2'd0, 4'h0, 64'h100, 64'h0, 1, 1'b0, 64'h1);
    reset_in_wait();
    access(2'd0, 4'h5, 64'h208, 64'h0, 2, 1'b0, 64'h0123456789ABCDEF);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [1:0]  st;
      logic [3:0]  ic;
      logic [63:0] ve;
      logic [63:0] va;
      int          sel;
      st  = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
      ic  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                        : 4'($urandom_range(4, 11));
      sel = $urandom_range(0, 9);
      ve  = (sel < 7) ? 64'($urandom_range(0, 8191)) :
            (sel == 7) ? 64'd8191 : (sel == 8) ? 64'd8192 : {$urandom, $urandom} | 64'h4000;
      sel = $urandom_range(0, 9);
      va  = (sel < 7) ? 64'($urandom_range(0, 8191)) :
            (sel == 7) ? 64'd8191 : (sel == 8) ? 64'd8192 : {$urandom, $urandom} | 64'h4000;
      access(st, ic, ve, va, $urandom_range(1, 19), 1'($urandom_range(0, 4) == 0),
             {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
